// File: rtl/cga_pkg.sv
// cga_pkg: shared constants and types for the CGA text-mode pixel generator.
//   - Default glyph cell geometry (8 pixels wide, 16 scanlines tall).
//   - Glyph bit order: bit 7 of a font byte is the leftmost pixel.
//   - Attribute byte layout: back I/R/G/B in bits 7..4, fore I/R/G/B in 3..0.
//   - Frame-counter bit indices that drive the blink and cursor phases.
package cga_pkg;

    localparam int DEF_CHAR_W = 8;
    localparam int DEF_CHAR_H = 16;

    // Leftmost pixel of a glyph row lives in the MSB of the font byte.
    localparam int GLYPH_MSB = 7;

    localparam int FRAME_W          = 5;
    localparam int BLINK_PHASE_BIT  = 4;  // 16 frames on, 16 off
    localparam int CURSOR_PHASE_BIT = 3;  // 8 frames on, 8 off

    typedef struct packed {
        logic       back_i;    // background intensity, or blink when enabled
        logic [2:0] back_rgb;
        logic [3:0] fore;      // foreground I/R/G/B
    } attr_t;

    function automatic logic glyph_bit(input logic [7:0] glyph, input logic [2:0] px);
        return glyph[3'(GLYPH_MSB) - px];
    endfunction

endpackage

// File: rtl/sig_delay.sv
// sig_delay: fixed-depth shift register with synchronous active-low reset.
// Used to keep de/hsync/vsync aligned with the pixel pipeline.
//   clk_i    pixel clock
//   rst_n_i  synchronous active-low reset, clears every tap
//   d_i      WIDTH-bit input
//   q_o      d_i delayed by DEPTH clocks
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q_o = taps[DEPTH-1];

endmodule

// File: rtl/cga_text_gen.sv
// cga_text_gen: text-mode pixel generator in front of the CGA colour stage.
// Three-stage pipeline: cell decode + text RAM address, font ROM address,
// glyph bit select with blink/cursor/blanking, then registered outputs.
//   clk_i, rst_n_i               pixel clock, synchronous active-low reset
//   x_i, y_i, de_i               pixel position and display enable
//   hsync_i, vsync_i             syncs (vsync rising edges count frames)
//   text_addr_o / text_data_i    text RAM, 1-cycle read ({attr, char})
//   font_addr_o / font_data_i    font ROM, 1-cycle read ({char, line})
//   blink_en_i                   attr[7] = blink (1) or back intensity (0)
//   cursor_en_i, cursor_col_i, cursor_row_i   underline cursor
//   color_o, on_o                {back IRGB, fore IRGB} and foreground flag
//   de_o, hsync_o, vsync_o       inputs delayed to match color_o/on_o
module cga_text_gen
    import cga_pkg::*;
#(
    parameter int COLS    = 60,
    parameter int ROWS    = 17,
    parameter int CHAR_W  = DEF_CHAR_W,
    parameter int CHAR_H  = DEF_CHAR_H,
    parameter int TADDR_W = 11
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [9:0]         x_i,
    input  logic [9:0]         y_i,
    input  logic               de_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [TADDR_W-1:0] text_addr_o,
    input  logic [15:0]        text_data_i,
    output logic [11:0]        font_addr_o,
    input  logic [7:0]         font_data_i,
    input  logic               blink_en_i,
    input  logic               cursor_en_i,
    input  logic [6:0]         cursor_col_i,
    input  logic [4:0]         cursor_row_i,
    output logic [7:0]         color_o,
    output logic               on_o,
    output logic               de_o,
    output logic               hsync_o,
    output logic               vsync_o
);

    localparam int PX_W = $clog2(CHAR_W);
    localparam int LN_W = $clog2(CHAR_H);

    localparam logic [TADDR_W-1:0] COLS_A = TADDR_W'(COLS);
    localparam logic [9:0]         COLS_C = 10'(COLS);
    localparam logic [9:0]         ROWS_C = 10'(ROWS);
    localparam logic [3:0]         LN_CUR = 4'(CHAR_H - 2);

    // ---- Stage T: cell decode, text RAM address ----
    logic [9:0]      col_p0, row_p0;
    logic [PX_W-1:0] px_p0;
    logic [3:0]      ln_p0;
    logic            vld_p0;

    assign col_p0      = x_i >> PX_W;
    assign row_p0      = y_i >> LN_W;
    assign px_p0       = x_i[PX_W-1:0];
    assign ln_p0       = 4'(y_i[LN_W-1:0]);
    assign vld_p0      = de_i && (col_p0 < COLS_C) && (row_p0 < ROWS_C);
    assign text_addr_o = TADDR_W'(row_p0) * COLS_A + TADDR_W'(col_p0);

    // ---- Stage T+1: text word arrives, font ROM address ----
    logic [9:0]      col_p1, row_p1;
    logic [PX_W-1:0] px_p1;
    logic [3:0]      ln_p1;
    logic            vld_p1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_p1 <= '0;
            row_p1 <= '0;
            px_p1  <= '0;
            ln_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            col_p1 <= col_p0;
            row_p1 <= row_p0;
            px_p1  <= px_p0;
            ln_p1  <= ln_p0;
            vld_p1 <= vld_p0;
        end
    end

    assign font_addr_o = {text_data_i[7:0], ln_p1};

    // ---- Stage T+2: glyph bit, blink, cursor, blanking ----
    logic [9:0]      col_p2, row_p2;
    logic [PX_W-1:0] px_p2;
    logic [3:0]      ln_p2;
    logic            vld_p2;
    attr_t           attr_p2;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_p2  <= '0;
            row_p2  <= '0;
            px_p2   <= '0;
            ln_p2   <= '0;
            vld_p2  <= 1'b0;
            attr_p2 <= '0;
        end else begin
            col_p2  <= col_p1;
            row_p2  <= row_p1;
            px_p2   <= px_p1;
            ln_p2   <= ln_p1;
            vld_p2  <= vld_p1;
            attr_p2 <= attr_t'(text_data_i[15:8]);
        end
    end

    // Frame counter. The edge detector resets to "high" so a vsync that is
    // already asserted when reset releases is not taken as a new frame.
    logic [FRAME_W-1:0] frame_cnt;
    logic               vsync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frame_cnt <= '0;
            vsync_q   <= 1'b1;
        end else begin
            vsync_q <= vsync_i;
            if (vsync_i && !vsync_q) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    logic pix_p2, cursor_hit, blink_ph;
    logic [7:0] color_nxt;
    logic       on_nxt;

    assign pix_p2     = glyph_bit(font_data_i, 3'(px_p2));
    assign blink_ph   = frame_cnt[BLINK_PHASE_BIT];
    assign cursor_hit = cursor_en_i && frame_cnt[CURSOR_PHASE_BIT]
                        && (col_p2 == 10'(cursor_col_i))
                        && (row_p2 == 10'(cursor_row_i))
                        && (ln_p2 >= LN_CUR);

    // Priority: blanking > cursor > blink > glyph bit.
    always_comb begin
        color_nxt = '0;
        on_nxt    = 1'b0;
        if (vld_p2) begin
            color_nxt = {attr_p2.back_i & ~blink_en_i, attr_p2.back_rgb, attr_p2.fore};
            on_nxt    = pix_p2;
            if (blink_en_i && attr_p2.back_i && blink_ph) on_nxt = 1'b0;
            if (cursor_hit) on_nxt = 1'b1;
        end
    end

    // ---- Output registers ----
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            color_o <= '0;
            on_o    <= 1'b0;
        end else begin
            color_o <= color_nxt;
            on_o    <= on_nxt;
        end
    end

    logic [2:0] sync_q;

    sig_delay #(
        .WIDTH (3),
        .DEPTH (3)
    ) u_sync_dly (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     ({de_i, hsync_i, vsync_i}),
        .q_o     (sync_q)
    );

    assign {de_o, hsync_o, vsync_o} = sync_q;

endmodule

// File: tb/tb_cga_text_gen.sv
// Bench for cga_text_gen: external text RAM / font ROM models, a behavioural
// per-pixel reference computed from cell arithmetic, and a 3-deep expected
// queue matching the fixed output latency.
module tb_cga_text_gen;

    localparam int COLS    = 60;
    localparam int ROWS    = 17;
    localparam int TADDR_W = 11;

    logic               clk = 1'b0;
    logic               rst_n_i;
    logic [9:0]         x_i, y_i;
    logic               de_i, hsync_i, vsync_i;
    logic [TADDR_W-1:0] text_addr_o;
    logic [15:0]        text_data_i;
    logic [11:0]        font_addr_o;
    logic [7:0]         font_data_i;
    logic               blink_en_i, cursor_en_i;
    logic [6:0]         cursor_col_i;
    logic [4:0]         cursor_row_i;
    logic [7:0]         color_o;
    logic               on_o, de_o, hsync_o, vsync_o;

    always #5 clk = ~clk;

    cga_text_gen #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(8), .CHAR_H(16), .TADDR_W(TADDR_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .x_i(x_i), .y_i(y_i), .de_i(de_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .text_addr_o(text_addr_o),
        .text_data_i(text_data_i), .font_addr_o(font_addr_o),
        .font_data_i(font_data_i), .blink_en_i(blink_en_i),
        .cursor_en_i(cursor_en_i), .cursor_col_i(cursor_col_i),
        .cursor_row_i(cursor_row_i), .color_o(color_o), .on_o(on_o),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    logic [15:0] tram [2048];
    logic [7:0]  font [4096];

    always @(posedge clk) begin
        text_data_i <= tram[text_addr_o];
        font_data_i <= font[font_addr_o];
    end

    typedef struct packed {
        logic [7:0] color;
        logic       on;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t pipe[$];
    exp_t due, obs;
    bit   due_vld;
    int   vectors = 0;
    int   miscompares = 0;
    int   frame = 0;
    bit   vs_prev = 1'b1;

    // Reference pixel: what the colour stage should see for this input.
    function automatic exp_t model(input int x, input int y, input bit de,
                                   input bit hs, input bit vs);
        exp_t e;
        int col, row, ln, px;
        logic [15:0] w;
        logic [7:0]  attr, g;
        e = '0;
        e.de = de; e.hs = hs; e.vs = vs;
        col = x / 8; px = x % 8;
        row = y / 16; ln = y % 16;
        if (de && col < COLS && row < ROWS) begin
            w    = tram[(row * COLS + col) % 2048];
            attr = w[15:8];
            g    = font[int'(w[7:0]) * 16 + ln];
            e.color = blink_en_i ? (attr & 8'h7F) : attr;
            e.on    = g[7 - px];
            if (blink_en_i && attr[7] && frame >= 16) e.on = 1'b0;
            if (cursor_en_i && col == int'(cursor_col_i) && row == int'(cursor_row_i)
                && ln >= 14 && (frame % 16) >= 8) e.on = 1'b1;
        end
        return e;
    endfunction

    // Advance one pixel: capture current outputs and the entry due now,
    // then apply new inputs and queue their expected result.
    task automatic drive(input int x, input int y, input bit de, input bit hs,
                         input bit vs, input bit rst_n);
        @(negedge clk);
        obs = {color_o, on_o, de_o, hsync_o, vsync_o};
        due_vld = 1'b0;
        if (pipe.size() == 3) begin
            due = pipe.pop_front();
            due_vld = 1'b1;
        end
        x_i = 10'(x); y_i = 10'(y);
        de_i = de; hsync_i = hs; vsync_i = vs;
        rst_n_i = rst_n;
        if (!rst_n) begin
            foreach (pipe[i]) pipe[i] = '0;
            pipe.push_back('0);
            frame = 0;
            vs_prev = 1'b1;
        end else begin
            if (vs && !vs_prev) frame = (frame + 1) % 32;
            vs_prev = vs;
            pipe.push_back(model(x, y, de, hs, vs));
        end
    endtask

    task automatic next_frame();
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            drive($urandom_range(0, 479), $urandom_range(0, 271), 1, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1);
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got {color,on,de,hs,vs}=%h want 000", obs);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, i[0], 0, 1);
            if (due_vld) begin
                vectors++;
                if (obs !== due) begin
                    miscompares++;
                    $display("FAIL reset_idle: got %h want %h", obs, due);
                end
            end
        end
    endtask

    task automatic test_pixel();
        tram[61] = 16'h1E41;
        font[12'h412] = 8'h18;
        drive(12, 18, 1, 0, 0, 1);
        #1;
        vectors++;
        if (text_addr_o !== 11'd61) begin
            miscompares++;
            $display("FAIL text_addr: got %0d want 61", text_addr_o);
        end
        drive(8, 18, 1, 0, 0, 1);
        #1;
        vectors++;
        if (font_addr_o !== 12'h412) begin
            miscompares++;
            $display("FAIL font_addr: got %h want 412", font_addr_o);
        end
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        vectors++;
        if (obs.color !== 8'h1E || obs.on !== 1'b1) begin
            miscompares++;
            $display("FAIL pixel_x12: got color=%h on=%b want color=1e on=1", obs.color, obs.on);
        end
        drive(0, 0, 0, 0, 0, 1);
        vectors++;
        if (obs.color !== 8'h1E || obs.on !== 1'b0) begin
            miscompares++;
            $display("FAIL pixel_x8: got color=%h on=%b want color=1e on=0", obs.color, obs.on);
        end
        for (int i = 0; i < 303; i++) begin
            if (i < 300)
                drive($urandom_range(0, 519), $urandom_range(0, 299),
                      $urandom_range(0, 9) != 0, $urandom_range(0, 1), 0, 1);
            else
                drive(0, 0, 0, 0, 0, 1);
            if (due_vld) begin
                vectors++;
                if (obs !== due) begin
                    miscompares++;
                    $display("FAIL pixel_random: got %h want %h", obs, due);
                end
            end
        end
    endtask

    task automatic test_blanking();
        int xs [8] = '{100, 480, 479, 0,   0,   639, 8, 200};
        int ys [8] = '{20,  20,  20,  272, 271, 399, 0, 100};
        bit ds [8] = '{0,   1,   1,   1,   1,   1,   0, 1};
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(xs[i], ys[i], ds[i], i[1], 0, 1);
            else       drive(0, 0, 0, 0, 0, 1);
            if (due_vld) begin
                vectors++;
                if (obs !== due) begin
                    miscompares++;
                    $display("FAIL blanking: got %h want %h", obs, due);
                end
            end
        end
    endtask

    // Covers both blink phases and the frame-counter wrap back to phase 0.
    task automatic test_blink();
        tram[185] = 16'h9F80;
        for (int i = 0; i < 16; i++) font[12'h800 + i] = 8'hFF;
        for (int pass = 0; pass < 2; pass++) begin
            blink_en_i = (pass == 0);
            for (int f = 0; f < 33; f++) begin
                for (int k = 0; k < 7; k++) begin
                    if (k < 4) drive(40 + $urandom_range(0, 7), 48 + $urandom_range(0, 15), 1, 0, 0, 1);
                    else       drive(0, 0, 0, 0, 0, 1);
                    if (due_vld) begin
                        vectors++;
                        if (obs !== due) begin
                            miscompares++;
                            $display("FAIL blink frame=%0d en=%0d: got %h want %h",
                                     frame, blink_en_i, obs, due);
                        end
                    end
                end
                next_frame();
            end
        end
    endtask

    task automatic test_cursor();
        tram[123] = 16'h8781;
        for (int i = 0; i < 16; i++) font[12'h810 + i] = 8'h00;
        blink_en_i = 1'b1;
        cursor_en_i = 1'b1;
        cursor_col_i = 7'd3;
        cursor_row_i = 5'd2;
        for (int f = 0; f < 32; f++) begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: drive(24 + $urandom_range(0, 7), 32 + 13, 1, 0, 0, 1);
                    1: drive(24 + $urandom_range(0, 7), 32 + 14, 1, 0, 0, 1);
                    2: drive(24 + $urandom_range(0, 7), 32 + 15, 1, 0, 0, 1);
                    3: drive(32 + $urandom_range(0, 7), 32 + 15, 1, 0, 0, 1);
                    4: drive(24 + $urandom_range(0, 7), 16 + 15, 1, 0, 0, 1);
                    default: drive(0, 0, 0, 0, 0, 1);
                endcase
                if (due_vld) begin
                    vectors++;
                    if (obs !== due) begin
                        miscompares++;
                        $display("FAIL cursor frame=%0d: got %h want %h", frame, obs, due);
                    end
                end
            end
            next_frame();
        end
    endtask

    task automatic test_reset_midline();
        while (frame != 20) next_frame();
        for (int x = 36; x < 63; x++) begin
            if (x < 60) drive(x, 50, 1, x[0], (x >= 44 && x < 47), x != 44);
            else        drive(0, 0, 0, 0, 0, 1);
            if (x == 45) begin
                vectors++;
                if (obs !== '0) begin
                    miscompares++;
                    $display("FAIL reset_midline_clear: got %h want 000", obs);
                end
            end
            if (due_vld) begin
                vectors++;
                if (obs !== due) begin
                    miscompares++;
                    $display("FAIL reset_midline x=%0d: got %h want %h", x, obs, due);
                end
            end
        end
        // Frame count must have restarted at 0: seven frames later the cursor
        // phase is still off.
        repeat (7) next_frame();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(26, 47, 1, 0, 0, 1);
            else        drive(0, 0, 0, 0, 0, 1);
            if (due_vld) begin
                vectors++;
                if (obs !== due) begin
                    miscompares++;
                    $display("FAIL frame_restart: got %h want %h", obs, due);
                end
            end
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        x_i = '0; y_i = '0;
        de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
        blink_en_i = 1'b0; cursor_en_i = 1'b0;
        cursor_col_i = '0; cursor_row_i = '0;
        for (int i = 0; i < 2048; i++) tram[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);

        test_reset();
        test_pixel();
        test_blanking();
        test_blink();
        test_cursor();
        test_reset_midline();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
